pc_gen_unit: RTL and testbench
==============================

Name: pc_gen_unit

Overview:
- Parametrised fetch-address generator; successor to the core's single-register PC.
- Adds a configurable reset vector, address width and step, and a valid/ready fetch request handshake that keeps the address stable while a request is outstanding.
- Adds pipeline hold and prioritised trap/branch redirects, with a pending-redirect buffer for redirects that arrive while a request is stalled.
- Sits between the ctrl/ex stages and the instruction bus interface.

Parameters:
- ADDR_W, 32, width of PC and redirect targets
- RESET_VEC, 32'h0000_0000, first fetch address after reset
- PC_STEP, 4, sequential increment in bytes (2 or 4 only)
- ALIGN_LSB, 2, number of low address bits forced to zero on every redirect target

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-low (rst==0 resets on posedge clk); single clock domain
- hold_i  in  1  pipeline stall; blocks issue of a new request
- branch_flag_i  in  1  branch/jump redirect strobe
- branch_addr_i  in  ADDR_W  branch target
- trap_flag_i  in  1  trap/mret redirect strobe; higher priority than branch
- trap_addr_i  in  ADDR_W  trap target
- req_valid_o  out  1  fetch request valid
- req_ready_i  in  1  bus accepts request
- pc  out  ADDR_W  request address (= req_addr)
- ce  out  1  fetch enable; 0 during reset and the following boot cycle
- redirect_o  out  1  one-cycle pulse: an accepted request carried a redirected address
- misalign_o  out  1  one-cycle pulse: a redirect target had nonzero bits below ALIGN_LSB

Behaviour:
- Reset (rst==0): pc=RESET_VEC, ce=0, req_valid_o=0, redirect_o=0, misalign_o=0, pending buffer cleared, state=BOOT. Reset mid-request abandons the request with no pulse.
- FSM has three states: BOOT, REQ, HOLD.
- BOOT: lasts one cycle after reset release; ce goes to 1. Next state is REQ, or HOLD if hold_i=1.
- REQ: req_valid_o=1.
  - While req_ready_i=0, pc and req_valid_o stay stable; a redirect strobe is captured into the pending buffer (target, misalign bit).
  - On handshake (valid & ready): next pc is selected by priority: same-cycle trap > same-cycle branch > pending > pc+PC_STEP.
  - A new same-cycle trap overwrites a pending branch. A new branch does not overwrite a pending trap captured earlier.
  - The buffer is cleared on use.
  - If hold_i=1 at the handshake, the next state is HOLD; otherwise stay in REQ.
- HOLD: req_valid_o=0; hold_i does not drop a valid that is already asserted.
  - A redirect strobe updates pc immediately (next cycle) using the same priority.
  - Leave HOLD for REQ the cycle after hold_i=0.
- Redirected target: low ALIGN_LSB bits forced to 0. misalign_o pulses in the cycle pc takes the target.
- redirect_o pulses in the cycle after handshake of a request whose pc came from a redirect. A redirect flag is kept alongside pc for this.
- Arithmetic: pc+PC_STEP wraps modulo 2^ADDR_W with no flag.
- Strobes are single-cycle; a level-held strobe is treated as repeated identical redirects.

Decomposition:
- bitty_defs.v gains the following constants:
  - PcStBoot, PcStReq, PcStHold (2-bit state encodings)
  - RstEnable redefined as 1'b0 for this block's polarity; existing uses are audited
  - TrapEnable
- Existing BranchEnable, ReadEnable and ZeroWord are reused.
- One sub-module: pc_redirect_buf, the pending target register with trap-over-branch priority and clear-on-use, about 60 lines.

Test Plan:
- Reset, then rst=1 with ready=1 and no hold: ce=0 for 1 cycle; then pc=0x0,0x4,0x8 with a handshake each cycle; redirect_o=0.
- ready=0 for 3 cycles at pc=0x10 with branch_flag_i pulsed at 0x200 in cycle 2: pc stays 0x10 and valid stays 1; after ready, pc=0x200 and redirect_o pulses once.
- Same cycle as handshake, trap=0x80 and branch=0x300: next pc=0x80. Then branch pending and a later trap during a stall: trap target wins.
- hold_i=1 during REQ with ready=0: valid stays 1 until the handshake, then 0. A branch to 0x44 while in HOLD gives pc=0x44; hold_i=0 reissues 0x44.
- Branch to 0x103 with ALIGN_LSB=2: pc=0x100 and misalign_o=1 for one cycle. pc=0xFFFF_FFFC sequential step: pc=0x0.
- rst=0 asserted while ready=0 with a pending trap: pc=RESET_VEC, the buffer is cleared, and no redirect is applied after reset.

Source files
------------

// File: rtl/pc_gen_unit_pkg.sv
// Shared constants and state encoding for the fetch-address generator.
// Imported by pc_gen_unit and its pending-redirect buffer.
package pc_gen_unit_pkg;

    localparam logic        RstEnable    = 1'b0;
    localparam logic        TrapEnable   = 1'b1;
    localparam logic        BranchEnable = 1'b1;
    localparam logic        ReadEnable   = 1'b1;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;

    typedef enum logic [1:0] {
        PcStBoot = 2'b00,
        PcStReq  = 2'b01,
        PcStHold = 2'b10
    } pc_state_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// Pending redirect target captured while a fetch request is stalled.
// A held trap is never displaced by a later branch; cleared when consumed.
module pc_redirect_buf #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_i,
    input  logic              clr_i,
    input  logic              trap_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              trap_mis_i,
    input  logic              br_i,
    input  logic [ADDR_W-1:0] br_addr_i,
    input  logic              br_mis_i,
    output logic              vld_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              mis_o
);
    import pc_gen_unit_pkg::*;

    logic              vld_q, vld_d;
    logic              trap_q, trap_d;
    logic              mis_q, mis_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        vld_d  = vld_q;
        trap_d = trap_q;
        mis_d  = mis_q;
        addr_d = addr_q;
        if (clr_i) begin
            vld_d  = 1'b0;
            trap_d = 1'b0;
            mis_d  = 1'b0;
        end else if (cap_i && trap_i) begin
            vld_d  = 1'b1;
            trap_d = 1'b1;
            mis_d  = trap_mis_i;
            addr_d = trap_addr_i;
        end else if (cap_i && br_i && !(vld_q && trap_q)) begin
            vld_d  = 1'b1;
            trap_d = 1'b0;
            mis_d  = br_mis_i;
            addr_d = br_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            vld_q  <= 1'b0;
            trap_q <= 1'b0;
            mis_q  <= 1'b0;
            addr_q <= ADDR_W'(ZeroWord);
        end else begin
            vld_q  <= vld_d;
            trap_q <= trap_d;
            mis_q  <= mis_d;
            addr_q <= addr_d;
        end
    end

    assign vld_o  = vld_q;
    assign addr_o = addr_q;
    assign mis_o  = mis_q;

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-address generator: boot/request/hold FSM with prioritised
// trap/branch redirects and a valid/ready request handshake.
module pc_gen_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                PC_STEP   = 4,
    parameter int                ALIGN_LSB = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    input  logic              trap_flag_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              redirect_o,
    output logic              misalign_o
);
    import pc_gen_unit_pkg::*;

    localparam logic [ADDR_W-1:0] LowMask =
        (ADDR_W'(1) << ALIGN_LSB) - ADDR_W'(1);
    localparam logic [ADDR_W-1:0] Step = ADDR_W'(PC_STEP);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q, ce_d;
    logic              valid_q, valid_d;
    logic              flag_q, flag_d;
    logic              redir_q, redir_d;
    logic              mis_q, mis_d;

    logic              trap_hit, br_hit, any_hit, hs;
    logic [ADDR_W-1:0] t_al, b_al, pend_addr, sel_addr;
    logic              t_mis, b_mis, pend_vld, pend_mis;
    logic              sel_mis, sel_redir, cap, clr;

    assign trap_hit = (trap_flag_i == TrapEnable);
    assign br_hit   = (branch_flag_i == BranchEnable);
    assign any_hit  = trap_hit || br_hit;
    assign hs       = valid_q && req_ready_i;
    assign t_al     = trap_addr_i & ~LowMask;
    assign b_al     = branch_addr_i & ~LowMask;
    assign t_mis    = |(trap_addr_i & LowMask);
    assign b_mis    = |(branch_addr_i & LowMask);

    pc_redirect_buf #(.ADDR_W(ADDR_W)) u_buf (
        .clk         (clk),
        .rst         (rst),
        .cap_i       (cap),
        .clr_i       (clr),
        .trap_i      (trap_hit),
        .trap_addr_i (t_al),
        .trap_mis_i  (t_mis),
        .br_i        (br_hit),
        .br_addr_i   (b_al),
        .br_mis_i    (b_mis),
        .vld_o       (pend_vld),
        .addr_o      (pend_addr),
        .mis_o       (pend_mis)
    );

    // Next-address source: trap > branch > pending > sequential.
    always_comb begin
        sel_redir = 1'b1;
        sel_mis   = 1'b0;
        sel_addr  = pc_q + Step;
        if (trap_hit) begin
            sel_addr = t_al;
            sel_mis  = t_mis;
        end else if (br_hit) begin
            sel_addr = b_al;
            sel_mis  = b_mis;
        end else if (pend_vld) begin
            sel_addr = pend_addr;
            sel_mis  = pend_mis;
        end else begin
            sel_redir = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ce_d    = ce_q;
        valid_d = valid_q;
        flag_d  = flag_q;
        redir_d = 1'b0;
        mis_d   = 1'b0;
        cap     = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            PcStReq: begin
                if (hs) begin
                    pc_d    = sel_addr;
                    flag_d  = sel_redir;
                    mis_d   = sel_mis;
                    redir_d = flag_q;
                    clr     = 1'b1;
                    valid_d = ReadEnable && !hold_i;
                    state_d = hold_i ? PcStHold : PcStReq;
                end else begin
                    cap = any_hit;
                end
            end
            PcStBoot, PcStHold: begin
                if (any_hit) begin
                    pc_d   = sel_addr;
                    flag_d = 1'b1;
                    mis_d  = sel_mis;
                end
                ce_d    = 1'b1;
                valid_d = ReadEnable && !hold_i;
                state_d = hold_i ? PcStHold : PcStReq;
            end
            default: begin
                state_d = PcStBoot;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= PcStBoot;
            pc_q    <= RESET_VEC;
            ce_q    <= 1'b0;
            valid_q <= 1'b0;
            flag_q  <= 1'b0;
            redir_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ce_q    <= ce_d;
            valid_q <= valid_d;
            flag_q  <= flag_d;
            redir_q <= redir_d;
            mis_q   <= mis_d;
        end
    end

    assign pc          = pc_q;
    assign ce          = ce_q;
    assign req_valid_o = valid_q;
    assign redirect_o  = redir_q;
    assign misalign_o  = mis_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed vector table plus randomized run against a behavioural model.
module tb_pc_gen_unit;

    logic        clk;
    logic        rst;
    logic        hold;
    logic        bf;
    logic [31:0] ba;
    logic        tf;
    logic [31:0] ta;
    logic        rdy;
    logic        valid;
    logic [31:0] pc;
    logic        ce;
    logic        rd;
    logic        mis;

    int n_tests = 0;
    int n_fail  = 0;

    pc_gen_unit dut (
        .clk           (clk),
        .rst           (rst),
        .hold_i        (hold),
        .branch_flag_i (bf),
        .branch_addr_i (ba),
        .trap_flag_i   (tf),
        .trap_addr_i   (ta),
        .req_valid_o   (valid),
        .req_ready_i   (rdy),
        .pc            (pc),
        .ce            (ce),
        .redirect_o    (rd),
        .misalign_o    (mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        hold;
        logic        rdy;
        logic        bf;
        logic [31:0] ba;
        logic        tf;
        logic [31:0] ta;
        logic [31:0] pc;
        logic        v;
        logic        ce;
        logic        rd;
        logic        mis;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic h, input logic rr,
                       input logic b, input logic [31:0] bad,
                       input logic t, input logic [31:0] tad,
                       input logic [31:0] epc, input logic ev,
                       input logic ece, input logic erd, input logic ems);
        vec_t e;
        e.rst = r; e.hold = h; e.rdy = rr;
        e.bf = b; e.ba = bad; e.tf = t; e.ta = tad;
        e.pc = epc; e.v = ev; e.ce = ece; e.rd = erd; e.mis = ems;
        tbl.push_back(e);
    endtask

    // Behavioural reference: fetch address, handshake and pending redirect.
    bit [31:0] m_pc, p_tgt;
    bit m_valid, m_ce, m_rd, m_mis, m_boot, m_flag;
    bit p_have, p_trap, p_mis;

    task automatic model_step();
        bit        r;
        bit [31:0] tg;
        bit        ms;
        bit        nrd;
        bit        nms;
        if (!rst) begin
            m_pc = 32'h0; m_valid = 0; m_ce = 0; m_rd = 0; m_mis = 0;
            m_boot = 1; m_flag = 0; p_have = 0; p_trap = 0; p_mis = 0;
            return;
        end
        r  = tf || bf;
        tg = tf ? ta : ba;
        ms = (tg % 4) != 0;
        tg = tg - (tg % 4);
        nrd = 0;
        nms = 0;
        if (m_boot) begin
            m_boot = 0;
            m_ce = 1;
            if (r) begin m_pc = tg; m_flag = 1; nms = ms; end
            m_valid = !hold;
        end else if (m_valid) begin
            if (rdy) begin
                nrd = m_flag;
                if (r) begin
                    m_pc = tg; m_flag = 1; nms = ms;
                end else if (p_have) begin
                    m_pc = p_tgt; m_flag = 1; nms = p_mis;
                end else begin
                    m_pc = m_pc + 32'd4; m_flag = 0;
                end
                p_have = 0;
                m_valid = !hold;
            end else if (tf) begin
                p_have = 1; p_trap = 1; p_tgt = tg; p_mis = ms;
            end else if (bf && !(p_have && p_trap)) begin
                p_have = 1; p_trap = 0; p_tgt = tg; p_mis = ms;
            end
        end else begin
            if (r) begin m_pc = tg; m_flag = 1; nms = ms; end
            if (!hold) m_valid = 1;
        end
        m_rd = nrd;
        m_mis = nms;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [35:0] got,
                         input logic [35:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got pc=%h v=%b ce=%b rd=%b mis=%b, expected pc=%h v=%b ce=%b rd=%b mis=%b",
                     name, got[35:4], got[3], got[2], got[1], got[0],
                     exp[35:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        rst = 0; hold = 0; bf = 0; ba = 0; tf = 0; ta = 0; rdy = 0;

        // reset, boot cycle, sequential fetch
        add(0,0,1, 0,0, 0,0, 32'h0,   0,0,0,0);
        add(0,0,1, 0,0, 0,0, 32'h0,   0,0,0,0);
        add(1,0,1, 0,0, 0,0, 32'h0,   1,1,0,0);
        add(1,0,1, 0,0, 0,0, 32'h4,   1,1,0,0);
        add(1,0,1, 0,0, 0,0, 32'h8,   1,1,0,0);
        add(1,0,1, 0,0, 0,0, 32'hC,   1,1,0,0);
        add(1,0,1, 0,0, 0,0, 32'h10,  1,1,0,0);
        // stall with branch captured into pending buffer
        add(1,0,0, 0,0, 0,0, 32'h10,  1,1,0,0);
        add(1,0,0, 1,32'h200, 0,0, 32'h10, 1,1,0,0);
        add(1,0,0, 0,0, 0,0, 32'h10,  1,1,0,0);
        add(1,0,1, 0,0, 0,0, 32'h200, 1,1,0,0);
        add(1,0,1, 0,0, 0,0, 32'h204, 1,1,1,0);
        add(1,0,1, 0,0, 0,0, 32'h208, 1,1,0,0);
        // same-cycle trap beats branch; pending trap beats later branch
        add(1,0,1, 1,32'h300, 1,32'h80, 32'h80, 1,1,0,0);
        add(1,0,0, 1,32'h300, 0,0, 32'h80, 1,1,0,0);
        add(1,0,0, 0,0, 1,32'h500, 32'h80, 1,1,0,0);
        add(1,0,0, 1,32'h600, 0,0, 32'h80, 1,1,0,0);
        add(1,0,1, 0,0, 0,0, 32'h500, 1,1,1,0);
        add(1,0,1, 0,0, 0,0, 32'h504, 1,1,1,0);
        add(1,0,1, 0,0, 0,0, 32'h508, 1,1,0,0);
        // hold keeps valid until handshake, redirect while held
        add(1,1,0, 0,0, 0,0, 32'h508, 1,1,0,0);
        add(1,1,0, 0,0, 0,0, 32'h508, 1,1,0,0);
        add(1,1,1, 0,0, 0,0, 32'h50C, 0,1,0,0);
        add(1,1,1, 1,32'h44, 0,0, 32'h44, 0,1,0,0);
        add(1,1,1, 0,0, 0,0, 32'h44,  0,1,0,0);
        add(1,0,0, 0,0, 0,0, 32'h44,  1,1,0,0);
        add(1,0,1, 0,0, 0,0, 32'h48,  1,1,1,0);
        // misaligned target and address wrap
        add(1,0,1, 1,32'h103, 0,0, 32'h100, 1,1,0,1);
        add(1,0,0, 0,0, 0,0, 32'h100, 1,1,0,0);
        add(1,0,1, 0,0, 0,0, 32'h104, 1,1,1,0);
        add(1,0,1, 1,32'hFFFF_FFFC, 0,0, 32'hFFFF_FFFC, 1,1,0,0);
        add(1,0,1, 0,0, 0,0, 32'h0,   1,1,1,0);
        // reset with a pending trap abandons it
        add(1,0,0, 0,0, 1,32'h900, 32'h0, 1,1,0,0);
        add(0,0,0, 0,0, 0,0, 32'h0,   0,0,0,0);
        add(1,0,1, 0,0, 0,0, 32'h0,   1,1,0,0);
        add(1,0,1, 0,0, 0,0, 32'h4,   1,1,0,0);
        add(1,0,1, 0,0, 0,0, 32'h8,   1,1,0,0);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; hold = tbl[i].hold; rdy = tbl[i].rdy;
            bf = tbl[i].bf; ba = tbl[i].ba; tf = tbl[i].tf; ta = tbl[i].ta;
            tick();
            check($sformatf("vec%0d", i), {pc, valid, ce, rd, mis},
                  {tbl[i].pc, tbl[i].v, tbl[i].ce, tbl[i].rd, tbl[i].mis});
        end

        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 63) != 0);
            hold = ($urandom_range(0, 3) == 0);
            rdy  = ($urandom_range(0, 1) == 0);
            bf   = ($urandom_range(0, 7) == 0);
            tf   = ($urandom_range(0, 15) == 0);
            ba   = $urandom;
            ta   = $urandom;
            if ($urandom_range(0, 1) == 0) ba[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 0) ta[1:0] = 2'b00;
            tick();
            check($sformatf("rand%0d", i), {pc, valid, ce, rd, mis},
                  {m_pc, m_valid, m_ce, m_rd, m_mis});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
